// File: rtl/crop_bbox.sv
// crop_bbox: bounding box of thresholded "hit" pixels inside a fixed ROI,
// published once per completed frame with a one-cycle strobe.
// Optional feature macro: CROP_BBOX_COUNT_EN builds the saturating ROI hit
// counter behind oCOUNT; without it oCOUNT is constant 0.
module crop_bbox #(
  parameter int DW     = 10,
  parameter int CW     = 16,
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int ROI_X0 = 160,
  parameter int ROI_X1 = 480,
  parameter int ROI_Y0 = 50,
  parameter int ROI_Y1 = 240
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iDVAL,
  input  logic [DW-1:0] iDATA,
  input  logic [DW-1:0] iTHRESH,
  input  logic          iSOF,
  output logic          oDVAL,
  output logic [CW-1:0] oXSTART,
  output logic [CW-1:0] oXEND,
  output logic [CW-1:0] oYSTART,
  output logic [CW-1:0] oYEND,
  output logic          oFOUND,
  output logic          oVALID,
  output logic [CW-1:0] oCOUNT
);

  localparam logic [CW-1:0] X_LAST = CW'(H_ACT - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_ACT - 1);
  localparam logic [CW-1:0] RX0    = CW'(ROI_X0);
  localparam logic [CW-1:0] RX1    = CW'(ROI_X1);
  localparam logic [CW-1:0] RY0    = CW'(ROI_Y0);
  localparam logic [CW-1:0] RY1    = CW'(ROI_Y1);

  logic [CW-1:0] r_x, r_y;
  logic [CW-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic          r_any;

  logic [CW-1:0] w_x, w_y;
  logic          w_hit, w_eof, w_base_any;
  logic [CW-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic          w_any;

  // iSOF forces the current pixel to (0,0) and discards the running box
  assign w_x        = iSOF ? '0 : r_x;
  assign w_y        = iSOF ? '0 : r_y;
  assign w_base_any = r_any && !iSOF;
  assign w_hit      = iDVAL && (w_x >= RX0) && (w_x <= RX1) &&
                      (w_y >= RY0) && (w_y <= RY1) && (iDATA <= iTHRESH);
  assign w_eof      = iDVAL && (w_x == X_LAST) && (w_y == Y_LAST);

  // Next running box: base (cleared on resync) merged with the current hit
  always_comb begin
    w_xmin = iSOF ? '0 : r_xmin;
    w_xmax = iSOF ? '0 : r_xmax;
    w_ymin = iSOF ? '0 : r_ymin;
    w_ymax = iSOF ? '0 : r_ymax;
    w_any  = w_base_any;
    if (w_hit) begin
      w_any = 1'b1;
      if (!w_base_any) begin
        w_xmin = w_x;
        w_xmax = w_x;
        w_ymin = w_y;
        w_ymax = w_y;
      end else begin
        if (w_x < w_xmin) w_xmin = w_x;
        if (w_x > w_xmax) w_xmax = w_x;
        if (w_y < w_ymin) w_ymin = w_y;
        if (w_y > w_ymax) w_ymax = w_y;
      end
    end
  end

  // Raster position: advances on valid pixels only, frozen during gaps
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_x <= '0;
      r_y <= '0;
    end else if (iDVAL) begin
      if (w_x == X_LAST) begin
        r_x <= '0;
        r_y <= (w_y == Y_LAST) ? '0 : w_y + 1'b1;
      end else begin
        r_x <= w_x + 1'b1;
        r_y <= w_y;
      end
    end else if (iSOF) begin
      r_x <= '0;
      r_y <= '0;
    end
  end

  // Running box and published results; frame end latches then clears
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymin  <= '0;
      r_ymax  <= '0;
      r_any   <= 1'b0;
      oDVAL   <= 1'b0;
      oVALID  <= 1'b0;
      oXSTART <= '0;
      oXEND   <= '0;
      oYSTART <= '0;
      oYEND   <= '0;
      oFOUND  <= 1'b0;
    end else begin
      oDVAL  <= iDVAL;
      oVALID <= w_eof;
      if (w_eof) begin
        oXSTART <= w_any ? w_xmin : '0;
        oXEND   <= w_any ? w_xmax : '0;
        oYSTART <= w_any ? w_ymin : '0;
        oYEND   <= w_any ? w_ymax : '0;
        oFOUND  <= w_any;
        r_xmin  <= '0;
        r_xmax  <= '0;
        r_ymin  <= '0;
        r_ymax  <= '0;
        r_any   <= 1'b0;
      end else if (iDVAL || iSOF) begin
        r_xmin <= w_xmin;
        r_xmax <= w_xmax;
        r_ymin <= w_ymin;
        r_ymax <= w_ymax;
        r_any  <= w_any;
      end
    end
  end

`ifdef CROP_BBOX_COUNT_EN
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_base, w_cnt;

  assign w_cnt_base = iSOF ? '0 : r_cnt;
  assign w_cnt      = (w_hit && (w_cnt_base != '1)) ? w_cnt_base + 1'b1 : w_cnt_base;

  // Saturating ROI hit counter, published and cleared with the box
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_cnt  <= '0;
      oCOUNT <= '0;
    end else if (w_eof) begin
      oCOUNT <= w_cnt;
      r_cnt  <= '0;
    end else if (iDVAL || iSOF) begin
      r_cnt <= w_cnt;
    end
  end
`else
  assign oCOUNT = '0;
`endif

endmodule

// File: tb/tb_crop_bbox.sv
// Self-checking bench for crop_bbox on a reduced 40x24 raster with an 8-bit
// coordinate width so count saturation is reachable.
module tb_crop_bbox;

  localparam int DW = 10;
  localparam int CW = 8;
  localparam int H  = 40;
  localparam int V  = 24;
  localparam int X0 = 10;
  localparam int X1 = 35;
  localparam int Y0 = 5;
  localparam int Y1 = 18;
  localparam int NPIX = H * V;
  localparam int CMAX = (1 << CW) - 1;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iDVAL = 1'b0;
  logic [DW-1:0] iDATA = '0;
  logic [DW-1:0] iTHRESH = '0;
  logic          iSOF = 1'b0;
  logic          oDVAL, oFOUND, oVALID;
  logic [CW-1:0] oXSTART, oXEND, oYSTART, oYEND, oCOUNT;

  int n_err = 0;
  int n_chk = 0;
  int n_strobe = 0;

  crop_bbox #(
    .DW(DW), .CW(CW), .H_ACT(H), .V_ACT(V),
    .ROI_X0(X0), .ROI_X1(X1), .ROI_Y0(Y0), .ROI_Y1(Y1)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iDATA(iDATA),
    .iTHRESH(iTHRESH), .iSOF(iSOF), .oDVAL(oDVAL),
    .oXSTART(oXSTART), .oXEND(oXEND), .oYSTART(oYSTART), .oYEND(oYEND),
    .oFOUND(oFOUND), .oVALID(oVALID), .oCOUNT(oCOUNT)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) if (oVALID) n_strobe++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One accepted pixel after an optional idle gap; returns #1 after its edge
  task automatic pix(input logic [DW-1:0] d, input logic [DW-1:0] th,
                     input logic sof, input int gap);
    for (int g = 0; g < gap; g++) begin
      iDVAL = 1'b0;
      @(posedge iCLK); #1;
    end
    iDVAL = 1'b1; iDATA = d; iTHRESH = th; iSOF = sof;
    @(posedge iCLK); #1;
    iDVAL = 1'b0; iSOF = 1'b0;
  endtask

  function automatic bit dark(input int mode, input int x, input int y);
    case (mode)
      1: return x == 12 && y == 7;
      2: return x >= 8 && x <= 20 && y >= 3 && y <= 8;
      3: return (x == 10 && y == 5) || (x == 35 && y == 18) || (x == 9 && y == 5) ||
                (x == 36 && y == 18) || (x == 10 && y == 4) || (x == 35 && y == 19);
      6: return 1'b1;
      7: return x == 20 && y == 12;
      8: return x == 11 && y == 6;
      default: return 1'b0;
    endcase
  endfunction

  // Drive n_pix pixels of a frame; a full frame is checked against the model
  task automatic run_frame(input string nm, input int mode, input int gap_max,
                           input int n_pix, input bit sof_first);
    int xmin, xmax, ymin, ymax, cnt, s0, th, d, x, y;
    bit any;
    any = 0; cnt = 0; xmin = 0; xmax = 0; ymin = 0; ymax = 0;
    s0 = n_strobe;
    th = $urandom_range(0, 60);
    for (int k = 0; k < n_pix; k++) begin
      x = k % H;
      y = k / H;
      if (mode == 4) begin
        if ($urandom_range(0, 49) == 0) th = $urandom_range(0, 60);
        d = $urandom_range(0, 1023);
      end else if (mode == 5) begin
        th = 500;
        d = (x == 20 && y == 10) ? 500 : 501;
      end else begin
        th = 0;
        d = dark(mode, x, y) ? 0 : 1023;
      end
      if (x >= X0 && x <= X1 && y >= Y0 && y <= Y1 && d <= th) begin
        if (!any) begin
          xmin = x; xmax = x; ymin = y; ymax = y;
        end else begin
          xmin = (x < xmin) ? x : xmin;
          xmax = (x > xmax) ? x : xmax;
          ymin = (y < ymin) ? y : ymin;
          ymax = (y > ymax) ? y : ymax;
        end
        any = 1;
        cnt++;
      end
      pix(DW'(d), DW'(th), sof_first && k == 0, $urandom_range(0, gap_max));
    end
`ifndef CROP_BBOX_COUNT_EN
    cnt = 0;
`endif
    if (cnt > CMAX) cnt = CMAX;
    if (n_pix == NPIX) begin
      chk({nm, ".vld"}, 32'(oVALID), 1);
      chk({nm, ".found"}, 32'(oFOUND), 32'(any));
      chk({nm, ".xs"}, 32'(oXSTART), xmin);
      chk({nm, ".xe"}, 32'(oXEND), xmax);
      chk({nm, ".ys"}, 32'(oYSTART), ymin);
      chk({nm, ".ye"}, 32'(oYEND), ymax);
      chk({nm, ".cnt"}, 32'(oCOUNT), cnt);
      @(posedge iCLK); #1;
      chk({nm, ".vld_off"}, 32'(oVALID), 0);
      chk({nm, ".dval_off"}, 32'(oDVAL), 0);
      chk({nm, ".hold_xe"}, 32'(oXEND), xmax);
      chk({nm, ".strobes"}, n_strobe - s0, 1);
    end else begin
      chk({nm, ".nopub"}, n_strobe - s0, 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst.vld", 32'(oVALID), 0);
    chk("rst.found", 32'(oFOUND), 0);
    chk("rst.xs", 32'(oXSTART), 0);
    chk("rst.ye", 32'(oYEND), 0);
    chk("rst.cnt", 32'(oCOUNT), 0);
    iRST = 1'b0;

    // oDVAL follows iDVAL by one cycle
    pix(1023, 0, 1'b1, 0);
    chk("dval", 32'(oDVAL), 1);
    iSOF = 1'b1; @(posedge iCLK); #1; iSOF = 1'b0;

    run_frame("white", 0, 0, NPIX, 0);
    run_frame("single", 1, 0, NPIX, 0);
    run_frame("rect", 2, 1, NPIX, 0);
    run_frame("corners", 3, 3, NPIX, 0);
    run_frame("rand_a", 4, 2, NPIX, 0);
    run_frame("thr_eq", 5, 0, NPIX, 0);
    run_frame("dark", 6, 0, NPIX, 0);
    run_frame("rand_b", 4, 1, NPIX, 0);

    // Aborted frame via isolated iSOF, then a clean frame
    run_frame("abort1", 7, 1, 600, 0);
    iSOF = 1'b1; @(posedge iCLK); #1; iSOF = 1'b0;
    chk("abort1.sof_nopub", 32'(oVALID), 0);
    run_frame("clean1", 8, 1, NPIX, 0);

    // Aborted frame via iSOF carried on the first pixel of the next frame
    run_frame("abort2", 7, 0, 600, 0);
    run_frame("clean2", 8, 0, NPIX, 1);

    // Reset mid-frame after a non-empty publish
    run_frame("pre_rst", 3, 0, NPIX, 0);
    run_frame("part_rst", 2, 0, 300, 0);
    iRST = 1'b1; @(posedge iCLK); #1; iRST = 1'b0;
    chk("mrst.vld", 32'(oVALID), 0);
    chk("mrst.found", 32'(oFOUND), 0);
    chk("mrst.xs", 32'(oXSTART), 0);
    chk("mrst.xe", 32'(oXEND), 0);
    chk("mrst.ys", 32'(oYSTART), 0);
    chk("mrst.ye", 32'(oYEND), 0);
    chk("mrst.cnt", 32'(oCOUNT), 0);
    chk("mrst.dval", 32'(oDVAL), 0);
    run_frame("post_rst", 1, 1, NPIX, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
